if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 139 +++++++++++++
 tb/tb_if_stage.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: fetch PC, single-outstanding instruction memory
// request FSM and a 2-entry {pc, inst} buffer feeding decode.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic [6:0]  opcode
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, KILL} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ipc_q, ipc_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] pc0_q, pc0_d, in0_q, in0_d;
   logic [31:0] pc1_q, pc1_d, in1_q, in1_d;
   logic        req, push, pop;

   assign req  = (state_q == REQ) && (cnt_q != 2'd2) && !redirect_valid;
   assign pop  = (cnt_q != 2'd0) && inst_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ipc_d   = ipc_q;
      push    = 1'b0;
      unique case (state_q)
         IDLE: state_d = REQ;
         REQ: begin
            if (req && imem_gnt) begin
               pc_d    = pc_q + 32'd4;
               ipc_d   = pc_q;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (imem_rvalid) begin
               state_d = REQ;
               push    = !redirect_valid;
            end else if (redirect_valid) begin
               state_d = KILL;
            end
         end
         KILL: begin
            // The response being killed retires the only outstanding request,
            // so it always returns to REQ even if another redirect lands now.
            if (imem_rvalid) state_d = REQ;
         end
         default: state_d = IDLE;
      endcase
      if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
   end

   // A push only follows a grant made with fewer than 2 entries, and pops
   // never add entries, so the buffer cannot overflow.
   always_comb begin
      cnt_d = cnt_q;
      pc0_d = pc0_q;
      in0_d = in0_q;
      pc1_d = pc1_q;
      in1_d = in1_q;
      if (redirect_valid) begin
         cnt_d = 2'd0;
      end else begin
         unique case ({push, pop})
            2'b01: begin
               pc0_d = pc1_q;
               in0_d = in1_q;
               cnt_d = cnt_q - 2'd1;
            end
            2'b10: begin
               if (cnt_q == 2'd0) begin
                  pc0_d = ipc_q;
                  in0_d = imem_rdata;
               end else begin
                  pc1_d = ipc_q;
                  in1_d = imem_rdata;
               end
               cnt_d = cnt_q + 2'd1;
            end
            2'b11: begin
               if (cnt_q == 2'd1) begin
                  pc0_d = ipc_q;
                  in0_d = imem_rdata;
               end else begin
                  pc0_d = pc1_q;
                  in0_d = in1_q;
                  pc1_d = ipc_q;
                  in1_d = imem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         ipc_q   <= '0;
         cnt_q   <= '0;
         pc0_q   <= '0;
         in0_q   <= '0;
         pc1_q   <= '0;
         in1_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ipc_q   <= ipc_d;
         cnt_q   <= cnt_d;
         pc0_q   <= pc0_d;
         in0_q   <= in0_d;
         pc1_q   <= pc1_d;
         in1_q   <= in1_d;
      end
   end

   assign imem_req   = req;
   assign imem_addr  = pc_q;
   assign inst_valid = (cnt_q != 2'd0);
   assign inst       = inst_valid ? in0_q : 32'd0;
   assign inst_pc    = inst_valid ? pc0_q : 32'd0;
   assign opcode     = inst[6:0];

endmodule

// File: tb/tb_if_stage.sv
// Randomized scoreboard bench for if_stage: the expected instruction stream is
// "sequential words from the last redirect/reset target", read from a memory hash.
module tb_if_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic        imem_req, imem_gnt, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        redirect_valid, inst_valid, inst_ready;
   logic [31:0] redirect_pc, inst, inst_pc;
   logic [6:0]  opcode;

   if_stage #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rstn(rstn),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst(inst), .inst_pc(inst_pc), .opcode(opcode)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;

   int checks = 0, failures = 0, pops = 0;
   ent_t exp_q[$];
   logic [31:0] tail_pc, exp_fetch, hold_addr;
   logic [31:0] gseq[$];
   bit hold_pend = 0, run = 0;

   // memory responder state
   bit gnt_rand = 0;
   int lat_lo = 1, lat_hi = 1;
   bit pend = 0;
   int dly = 0;
   logic [31:0] pend_addr;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic topup();
      while (exp_q.size() < 8) begin
         exp_q.push_back('{pc: tail_pc, ins: mem(tail_pc)});
         tail_pc = tail_pc + 32'd4;
      end
   endtask

   task automatic refill(input logic [31:0] t);
      exp_q.delete();
      tail_pc   = t;
      exp_fetch = t;
      topup();
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      ent_t e;
      if (rstn && run) begin
         if (hold_pend && !redirect_valid) begin
            chk("req_hold", {31'b0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, hold_addr);
         end
         if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
         if (imem_req && imem_gnt) begin
            chk("fetch_addr", imem_addr, exp_fetch);
            gseq.push_back(imem_addr);
            exp_fetch = exp_fetch + 32'd4;
         end
         if (inst_valid && inst_ready) begin
            e = exp_q.pop_front();
            chk("inst_pc", inst_pc, e.pc);
            chk("inst", inst, e.ins);
            chk("opcode", {25'b0, opcode}, {25'b0, e.ins[6:0]});
            pops++;
            topup();
         end else if (!inst_valid) begin
            chk("idle_zero", inst | inst_pc | {25'b0, opcode}, 32'd0);
         end
         if (redirect_valid) refill({redirect_pc[31:2], 2'b00});
         hold_pend = imem_req && !imem_gnt;
         hold_addr = imem_addr;
      end
   end

   // memory responder: samples grants mid-cycle, answers after lat cycles
   initial begin
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rstn) pend = 0;
         else begin
            if (imem_rvalid) pend = 0;
            if (imem_req && imem_gnt) begin
               pend = 1; pend_addr = imem_addr;
               dly = $urandom_range(lat_hi, lat_lo) - 1;
            end
         end
         @(posedge clk); #1;
         if (!rstn) pend = 0;
         imem_rvalid = pend && (dly == 0);
         imem_rdata  = (pend && dly == 0) ? mem(pend_addr) : $urandom;
         if (pend && dly > 0) dly--;
         imem_gnt = gnt_rand ? ($urandom_range(2, 0) != 0) : 1'b1;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset(input bit lat_check);
      int first;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      rstn = 1'b0;
      #1;
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst", inst | inst_pc | {25'b0, opcode}, 32'd0);
      hold_pend = 0;
      pend = 0;
      gseq.delete();
      refill(RESET_PC);
      @(posedge clk); #1;
      rstn = 1'b1;
      if (lat_check) begin
         first = 0;
         for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (inst_valid && first == 0) first = k;
         end
         chk("first_valid_cycle", first, 3);
      end
   endtask

   task automatic wait_grant(input string name, input logic [31:0] exp);
      bit ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (imem_req && imem_gnt) begin
            ok = 1;
            chk(name, imem_addr, exp);
         end
      end
      if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
      #2;
      run = 1;
      // reset release, fixed grant and 1-cycle latency
      do_reset(1'b1);
      cyc(6);
      chk("gseq_len", {31'b0, gseq.size() >= 3}, 32'd1);
      if (gseq.size() >= 3) begin
         chk("gseq0", gseq[0], 32'h0);
         chk("gseq1", gseq[1], 32'h4);
         chk("gseq2", gseq[2], 32'h8);
      end
      // decode stalled: buffer fills and fetching stops
      inst_ready = 1'b0;
      cyc(10);
      @(negedge clk);
      chk("full_req", {31'b0, imem_req}, 32'd0);
      chk("full_valid", {31'b0, inst_valid}, 32'd1);
      @(posedge clk); #1;
      inst_ready = 1'b1;
      cyc(6);
      // redirect during WAIT, stale response arrives later
      lat_lo = 3; lat_hi = 3;
      wait_grant("pre_kill_grant", exp_fetch);
      @(posedge clk); #1;
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      lat_lo = 1; lat_hi = 1;
      wait_grant("kill_next_addr", 32'h100);
      cyc(8);
      // redirect coinciding with the response
      wait_grant("pre_rv_grant", exp_fetch);
      @(posedge clk); #1;
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      wait_grant("rv_redirect_addr", 32'h200);
      cyc(6);
      // PC wrap at top of address space
      @(posedge clk); #1;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      wait_grant("wrap_top", 32'hFFFF_FFFC);
      wait_grant("wrap_zero", 32'h0);
      cyc(6);
      // async reset pulse while a fetch is in flight
      lat_lo = 3; lat_hi = 3;
      wait_grant("pre_reset_grant", exp_fetch);
      lat_lo = 1; lat_hi = 1;
      do_reset(1'b1);
      wait_grant("post_reset_addr", 32'h10);
      cyc(4);
      // randomized traffic
      gnt_rand = 1; lat_lo = 1; lat_hi = 4;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(499, 0) == 0) do_reset(1'b0);
         @(posedge clk); #1;
         inst_ready = ($urandom_range(3, 0) != 0);
         redirect_valid = ($urandom_range(15, 0) == 0);
         redirect_pc = ($urandom_range(7, 0) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15, 0)) : $urandom;
      end
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      cyc(4);
      chk("progress", {31'b0, pops >= 200}, 32'd1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
